master_arbiter_port: RTL

- Master-side endpoint of the serial arbitration link; the arbiter-side endpoint terminates the same two wires inside the bus controller.
- Converts the master core's parallel request/release handshake into serial frames on arb_out.
- Decodes grant, split and preempt frames arriving on arb_in and reports bus ownership to the core.
- One instance per master, sitting between the master core and its controller-facing pins.

---
 rtl/master_arbiter_port.sv | 138 +++++++++++++
 1 files changed

// File: rtl/master_arbiter_port.sv
// master_arbiter_port: master-side serial arbitration link endpoint (request/ack framing, grant/split/preempt decode)
module master_arbiter_port #(
    parameter int NO_SLAVES  = 3,
    parameter int S_ID_WIDTH = $clog2(NO_SLAVES + 1)
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  req,
    input  logic [S_ID_WIDTH-1:0] req_id,
    input  logic                  accept,
    input  logic                  release_i,
    input  logic                  arb_in,
    output logic                  arb_out,
    output logic                  grant,
    output logic                  suspended,
    output logic                  preempted,
    output logic                  nak_pulse,
    output logic                  busy
);
    localparam int L  = 3 + S_ID_WIDTH;
    localparam int CW = $clog2(L + 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT_GRANT, ACK, COMM, REL, SPLIT_ACK, SPLIT_WAIT} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [S_ID_WIDTH-1:0] id_q, id_d;
    logic                  acc_q, acc_d;
    logic                  rin_q;
    logic                  out_q, out_d;
    logic                  nak_q, nak_d;
    logic                  pre_q, pre_d;
    logic [L-1:0]          req_sh;
    logic [2:0]            ack_sh, spl_sh;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            id_q    <= '0;
            acc_q   <= 1'b0;
            rin_q   <= 1'b0;
            out_q   <= 1'b0;
            nak_q   <= 1'b0;
            pre_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            acc_q   <= acc_d;
            rin_q   <= arb_in;
            out_q   <= out_d;
            nak_q   <= nak_d;
            pre_q   <= pre_d;
        end
    end

    // cnt_q counts bits already on the line; the next bit is the MSB of the shifted pattern
    always_comb begin
        req_sh  = {3'b111, id_q} << cnt_q;
        ack_sh  = (acc_q ? 3'b101 : 3'b110) << cnt_q;
        spl_sh  = 3'b010 << cnt_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        acc_d   = acc_q;
        out_d   = 1'b0;
        nak_d   = 1'b0;
        pre_d   = 1'b0;
        case (state_q)
            IDLE: if (req) begin
                state_d = REQ;
                id_d    = req_id;
                cnt_d   = CW'(1);
                out_d   = 1'b1;
            end
            REQ: if (cnt_q == CW'(L)) begin
                state_d = WAIT_GRANT;
                cnt_d   = '0;
            end else begin
                out_d = req_sh[L-1];
                cnt_d = cnt_q + 1'b1;
            end
            WAIT_GRANT, SPLIT_WAIT: if (cnt_q == '0) begin
                cnt_d = CW'(rin_q);
            end else begin
                state_d = ACK;
                acc_d   = accept;
                cnt_d   = CW'(1);
                out_d   = 1'b1;
            end
            ACK: if (cnt_q == CW'(3)) begin
                state_d = acc_q ? COMM : IDLE;
                out_d   = acc_q;
                cnt_d   = '0;
            end else begin
                out_d = ack_sh[2];
                nak_d = !acc_q && cnt_q == CW'(2);
                cnt_d = cnt_q + 1'b1;
            end
            COMM: if (release_i) begin
                state_d = REL;
                cnt_d   = CW'(1);
            end else if (cnt_q == '0) begin
                out_d = 1'b1;
                cnt_d = CW'(rin_q);
            end else begin
                state_d = rin_q ? IDLE : SPLIT_ACK;
                pre_d   = rin_q;
                cnt_d   = CW'(!rin_q);
            end
            REL: if (cnt_q == CW'(1)) begin
                out_d = 1'b1;
                cnt_d = CW'(2);
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            SPLIT_ACK: if (cnt_q == CW'(3)) begin
                state_d = SPLIT_WAIT;
                cnt_d   = '0;
            end else begin
                out_d = spl_sh[2];
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        arb_out   = out_q;
        grant     = state_q == COMM;
        suspended = state_q == SPLIT_ACK || state_q == SPLIT_WAIT;
        busy      = state_q != IDLE;
        preempted = pre_q;
        nak_pulse = nak_q;
    end
endmodule
